// File: rtl/rv_iopmp_error_capture_rr.sv
// Round-robin error logger: accepts one IOPMP error record per cycle into a small FIFO and
// commits the FIFO head to the ERR_REQ* registers whenever ERR_REQINFO.ip is clear.

package rv_iopmp_pkg;

    typedef struct packed {
        logic        error_detected;
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [15:0] sid;
        logic [15:0] eid;
        logic [63:0] addr;
    } error_capture_t;

    typedef struct packed {
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [15:0] sid;
        logic [15:0] eid;
        logic [63:0] addr;
    } err_entry_t;

    typedef struct packed {
        struct packed { logic q;       } ip;
        struct packed { logic [1:0] q; } ttype;
        struct packed { logic [2:0] q; } etype;
    } reg2hw_err_reqinfo_reg_t;

    typedef struct packed {
        struct packed { logic [15:0] q; } eid;
        struct packed { logic [15:0] q; } sid;
    } reg2hw_err_reqid_reg_t;

    typedef struct packed { logic [31:0] q; } reg2hw_err_reqaddr_reg_t;
    typedef struct packed { logic [31:0] q; } reg2hw_err_reqaddrh_reg_t;

    typedef struct packed {
        struct packed { logic d;       logic de; } ip;
        struct packed { logic [1:0] d; logic de; } ttype;
        struct packed { logic [2:0] d; logic de; } etype;
    } hw2reg_err_reqinfo_reg_t;

    typedef struct packed {
        struct packed { logic [15:0] d; logic de; } eid;
        struct packed { logic [15:0] d; logic de; } sid;
    } hw2reg_err_reqid_reg_t;

    typedef struct packed { logic [31:0] d; logic de; } hw2reg_err_reqaddr_reg_t;
    typedef struct packed { logic [31:0] d; logic de; } hw2reg_err_reqaddrh_reg_t;

endpackage

module rv_iopmp_error_capture_rr
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NUMBER_IOPMP_INSTANCES = 4,
    parameter int unsigned FIFO_DEPTH             = 4,
    parameter int unsigned ERR_CNT_WIDTH          = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  reg2hw_err_reqinfo_reg_t                       reg2hw_err_reqinfo_i,
    input  reg2hw_err_reqid_reg_t                         reg2hw_err_reqid_i,
    input  reg2hw_err_reqaddr_reg_t                       reg2hw_err_reqaddr_i,
    input  reg2hw_err_reqaddrh_reg_t                      reg2hw_err_reqaddrh_i,
    output hw2reg_err_reqinfo_reg_t                       hw2reg_err_reqinfo_o,
    output hw2reg_err_reqid_reg_t                         hw2reg_err_reqid_o,
    output hw2reg_err_reqaddr_reg_t                       hw2reg_err_reqaddr_o,
    output hw2reg_err_reqaddrh_reg_t                      hw2reg_err_reqaddrh_o,
    input  error_capture_t [NUMBER_IOPMP_INSTANCES-1:0]   err_interface_i,
    output logic [NUMBER_IOPMP_INSTANCES-1:0]             err_ack_o,
    output logic [ERR_CNT_WIDTH-1:0]                      err_drop_cnt_o,
    input  logic                                          err_cnt_clr_i,
    output logic                                          err_overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]                   fifo_level_o
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW = PtrW + 1;
    localparam int unsigned RrW    = (NUMBER_IOPMP_INSTANCES > 1) ? $clog2(NUMBER_IOPMP_INSTANCES) : 1;
    localparam int unsigned SumW   = ERR_CNT_WIDTH + RrW + 1;

    err_entry_t                        fifo_q [FIFO_DEPTH];
    err_entry_t                        head;
    err_entry_t                        push_entry;
    logic [PtrW-1:0]                   wr_ptr_q, rd_ptr_q;
    logic [LevelW-1:0]                 level_q, level_d;
    logic [RrW-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [RrW-1:0]                    grant_idx;
    logic [ERR_CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [NUMBER_IOPMP_INSTANCES-1:0] req, grant_oh, dropped;
    logic                              push, pop, space;
    logic [SumW-1:0]                   sum;

    assign pop   = ~reg2hw_err_reqinfo_i.ip.q && (level_q != '0);
    assign space = (level_q < LevelW'(FIFO_DEPTH)) || pop;
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < NUMBER_IOPMP_INSTANCES; i++) begin
            req[i] = err_interface_i[i].error_detected;
        end
    end

    // First requester at or after rr_ptr_q wins; nothing is granted while in reset.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_oh  = '0;
        grant_idx = '0;
        push      = 1'b0;
        for (int unsigned k = 0; k < NUMBER_IOPMP_INSTANCES; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUMBER_IOPMP_INSTANCES) idx = idx - NUMBER_IOPMP_INSTANCES;
            if (!push && req[idx] && space && rst_ni) begin
                push          = 1'b1;
                grant_idx     = RrW'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        push_entry.ttype = err_interface_i[grant_idx].ttype;
        push_entry.etype = err_interface_i[grant_idx].etype;
        push_entry.sid   = err_interface_i[grant_idx].sid;
        push_entry.eid   = err_interface_i[grant_idx].eid;
        push_entry.addr  = err_interface_i[grant_idx].addr;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (32'(grant_idx) == NUMBER_IOPMP_INSTANCES - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    assign dropped = req & ~grant_oh;

    always_comb begin
        sum = SumW'(cnt_q);
        for (int i = 0; i < NUMBER_IOPMP_INSTANCES; i++) begin
            sum = sum + SumW'(dropped[i]);
        end
        if (err_cnt_clr_i) begin
            cnt_d = '0;
        end else if (sum > SumW'({ERR_CNT_WIDTH{1'b1}})) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[ERR_CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q  <= level_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    always_comb begin
        hw2reg_err_reqinfo_o.ip.d     = reg2hw_err_reqinfo_i.ip.q;
        hw2reg_err_reqinfo_o.ip.de    = 1'b0;
        hw2reg_err_reqinfo_o.ttype.d  = reg2hw_err_reqinfo_i.ttype.q;
        hw2reg_err_reqinfo_o.ttype.de = 1'b0;
        hw2reg_err_reqinfo_o.etype.d  = reg2hw_err_reqinfo_i.etype.q;
        hw2reg_err_reqinfo_o.etype.de = 1'b0;
        hw2reg_err_reqid_o.sid.d      = reg2hw_err_reqid_i.sid.q;
        hw2reg_err_reqid_o.sid.de     = 1'b0;
        hw2reg_err_reqid_o.eid.d      = reg2hw_err_reqid_i.eid.q;
        hw2reg_err_reqid_o.eid.de     = 1'b0;
        hw2reg_err_reqaddr_o.d        = reg2hw_err_reqaddr_i.q;
        hw2reg_err_reqaddr_o.de       = 1'b0;
        hw2reg_err_reqaddrh_o.d       = reg2hw_err_reqaddrh_i.q;
        hw2reg_err_reqaddrh_o.de      = 1'b0;
        if (pop) begin
            hw2reg_err_reqinfo_o.ip.d     = 1'b1;
            hw2reg_err_reqinfo_o.ip.de    = 1'b1;
            hw2reg_err_reqinfo_o.ttype.d  = head.ttype;
            hw2reg_err_reqinfo_o.ttype.de = 1'b1;
            hw2reg_err_reqinfo_o.etype.d  = head.etype;
            hw2reg_err_reqinfo_o.etype.de = 1'b1;
            hw2reg_err_reqid_o.sid.d      = head.sid;
            hw2reg_err_reqid_o.sid.de     = 1'b1;
            hw2reg_err_reqid_o.eid.d      = head.eid;
            hw2reg_err_reqid_o.eid.de     = 1'b1;
            hw2reg_err_reqaddr_o.d        = head.addr[31:0];
            hw2reg_err_reqaddr_o.de       = 1'b1;
            hw2reg_err_reqaddrh_o.d       = head.addr[63:32];
            hw2reg_err_reqaddrh_o.de      = 1'b1;
        end
    end

    assign err_ack_o      = grant_oh;
    assign err_drop_cnt_o = cnt_q;
    assign err_overflow_o = (cnt_q != '0);
    assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_rv_iopmp_error_capture_rr.sv
// Directed bench for rv_iopmp_error_capture_rr with a small ERR_REQ* register model and a
// scoreboard queue of expected commits.

module tb_rv_iopmp_error_capture_rr;
    import rv_iopmp_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    reg2hw_err_reqinfo_reg_t  reg2hw_err_reqinfo;
    reg2hw_err_reqid_reg_t    reg2hw_err_reqid;
    reg2hw_err_reqaddr_reg_t  reg2hw_err_reqaddr;
    reg2hw_err_reqaddrh_reg_t reg2hw_err_reqaddrh;
    hw2reg_err_reqinfo_reg_t  hw2reg_err_reqinfo;
    hw2reg_err_reqid_reg_t    hw2reg_err_reqid;
    hw2reg_err_reqaddr_reg_t  hw2reg_err_reqaddr;
    hw2reg_err_reqaddrh_reg_t hw2reg_err_reqaddrh;
    error_capture_t [3:0]     err_if = '0;
    logic [3:0]               err_ack;
    logic [7:0]               err_drop_cnt;
    logic                     err_cnt_clr = 1'b0;
    logic                     err_overflow;
    logic [2:0]               fifo_level;

    int         total = 0;
    int         bad   = 0;
    err_entry_t sb_q[$];
    logic       last_de;

    // Register model: hardware writes win over software set/clear of ip.
    logic        sw_ip_set = 1'b0;
    logic        sw_ip_clr = 1'b0;
    logic        ip_q;
    logic [1:0]  ttype_q;
    logic [2:0]  etype_q;
    logic [15:0] sid_q, eid_q;
    logic [31:0] addr_q, addrh_q;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ip_q <= 1'b0; ttype_q <= '0; etype_q <= '0;
            sid_q <= '0; eid_q <= '0; addr_q <= '0; addrh_q <= '0;
        end else begin
            if (hw2reg_err_reqinfo.ip.de) ip_q <= hw2reg_err_reqinfo.ip.d;
            else if (sw_ip_clr)           ip_q <= 1'b0;
            else if (sw_ip_set)           ip_q <= 1'b1;
            if (hw2reg_err_reqinfo.ttype.de) ttype_q <= hw2reg_err_reqinfo.ttype.d;
            if (hw2reg_err_reqinfo.etype.de) etype_q <= hw2reg_err_reqinfo.etype.d;
            if (hw2reg_err_reqid.sid.de)     sid_q   <= hw2reg_err_reqid.sid.d;
            if (hw2reg_err_reqid.eid.de)     eid_q   <= hw2reg_err_reqid.eid.d;
            if (hw2reg_err_reqaddr.de)       addr_q  <= hw2reg_err_reqaddr.d;
            if (hw2reg_err_reqaddrh.de)      addrh_q <= hw2reg_err_reqaddrh.d;
        end
    end

    assign reg2hw_err_reqinfo.ip.q    = ip_q;
    assign reg2hw_err_reqinfo.ttype.q = ttype_q;
    assign reg2hw_err_reqinfo.etype.q = etype_q;
    assign reg2hw_err_reqid.sid.q     = sid_q;
    assign reg2hw_err_reqid.eid.q     = eid_q;
    assign reg2hw_err_reqaddr.q       = addr_q;
    assign reg2hw_err_reqaddrh.q      = addrh_q;

    rv_iopmp_error_capture_rr #(
        .NUMBER_IOPMP_INSTANCES(4),
        .FIFO_DEPTH            (4),
        .ERR_CNT_WIDTH         (8)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .reg2hw_err_reqinfo_i (reg2hw_err_reqinfo),
        .reg2hw_err_reqid_i   (reg2hw_err_reqid),
        .reg2hw_err_reqaddr_i (reg2hw_err_reqaddr),
        .reg2hw_err_reqaddrh_i(reg2hw_err_reqaddrh),
        .hw2reg_err_reqinfo_o (hw2reg_err_reqinfo),
        .hw2reg_err_reqid_o   (hw2reg_err_reqid),
        .hw2reg_err_reqaddr_o (hw2reg_err_reqaddr),
        .hw2reg_err_reqaddrh_o(hw2reg_err_reqaddrh),
        .err_interface_i      (err_if),
        .err_ack_o            (err_ack),
        .err_drop_cnt_o       (err_drop_cnt),
        .err_cnt_clr_i        (err_cnt_clr),
        .err_overflow_o       (err_overflow),
        .fifo_level_o         (fifo_level)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every commit must match the oldest accepted record, all de bits together.
    always @(negedge clk_i) begin
        if (rst_ni && hw2reg_err_reqinfo.ip.de) begin
            err_entry_t obs, exp;
            obs = '{ttype: hw2reg_err_reqinfo.ttype.d, etype: hw2reg_err_reqinfo.etype.d,
                    sid: hw2reg_err_reqid.sid.d, eid: hw2reg_err_reqid.eid.d,
                    addr: {hw2reg_err_reqaddrh.d, hw2reg_err_reqaddr.d}};
            check("commit_de_all", {hw2reg_err_reqinfo.ip.d, hw2reg_err_reqinfo.ttype.de,
                  hw2reg_err_reqinfo.etype.de, hw2reg_err_reqid.sid.de, hw2reg_err_reqid.eid.de,
                  hw2reg_err_reqaddr.de, hw2reg_err_reqaddrh.de}, 7'h7f);
            if (sb_q.size() == 0) begin
                check("commit_unexpected", 1'b1, 1'b0);
            end else begin
                exp = sb_q.pop_front();
                check("commit_fields", obs, exp);
            end
        end
    end

    function automatic error_capture_t mk(input int i, input logic [31:0] addr,
                                          input logic [15:0] sid);
        error_capture_t r;
        r.error_detected = 1'b1;
        r.ttype = 2'(i);
        r.etype = 3'(i + 1);
        r.sid   = sid;
        r.eid   = 16'hE000 + 16'(i);
        r.addr  = {32'hCAFE0000 + 32'(i), addr};
        return r;
    endfunction

    function automatic err_entry_t to_entry(input error_capture_t r);
        return '{ttype: r.ttype, etype: r.etype, sid: r.sid, eid: r.eid, addr: r.addr};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    // One cycle of stimulus starting just after a rising edge; returns just after the next one.
    task automatic drive(input logic [3:0] mask, input logic [31:0] addr, input logic [15:0] sid,
                         input logic [3:0] exp_ack, input string tag);
        for (int i = 0; i < 4; i++) err_if[i] = mask[i] ? mk(i, addr, sid) : '0;
        for (int i = 0; i < 4; i++) if (exp_ack[i]) sb_q.push_back(to_entry(err_if[i]));
        @(negedge clk_i);
        check(tag, err_ack, exp_ack);
        last_de = hw2reg_err_reqinfo.ip.de;
        @(posedge clk_i); #1;
        err_if = '0;
    endtask

    task automatic clear_ip();
        sw_ip_clr = 1'b1; idle(1); sw_ip_clr = 1'b0; idle(1);
    endtask

    task automatic set_ip();
        sw_ip_set = 1'b1; idle(1); sw_ip_set = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; err_if = '0; sb_q.delete();
        idle(2);
        rst_ni = 1'b1;
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check("rst_level", fifo_level, 3'd0);
        check("rst_cnt", err_drop_cnt, 8'd0);
        check("rst_ack", err_ack, 4'd0);
        check("rst_de", hw2reg_err_reqinfo.ip.de, 1'b0);

        // 1: single error, empty FIFO, ip clear
        drive(4'b0100, 32'h1000, 16'd3, 4'b0100, "t1_ack");
        @(negedge clk_i);
        check("t1_de_t1", hw2reg_err_reqinfo.ip.de, 1'b1);
        @(posedge clk_i); #1;
        check("t1_ip_t2", ip_q, 1'b1);
        check("t1_level", fifo_level, 3'd0);
        @(negedge clk_i);
        check("t1_mirror_addr", hw2reg_err_reqaddr.d, 32'h1000);
        check("t1_mirror_de", hw2reg_err_reqaddr.de, 1'b0);
        @(posedge clk_i); #1;

        // 2: all four collide twice with ip set
        do_reset();
        set_ip();
        drive(4'b1111, 32'h2000, 16'd7, 4'b0001, "t2_ack0");
        check("t2_cnt3", err_drop_cnt, 8'd3);
        drive(4'b1111, 32'h2100, 16'd7, 4'b0010, "t2_ack1");
        check("t2_cnt6", err_drop_cnt, 8'd6);
        check("t2_level2", fifo_level, 3'd2);

        // 3: fill to full, one drop, then drain in order
        do_reset();
        set_ip();
        for (int i = 0; i < 4; i++) begin
            drive(4'(1 << i), 32'h3000 + 32'(i), 16'd30, 4'(1 << i), "t3_ack");
        end
        drive(4'b0001, 32'h3004, 16'd30, 4'b0000, "t3_ack_full");
        check("t3_level4", fifo_level, 3'd4);
        check("t3_cnt1", err_drop_cnt, 8'd1);
        check("t3_ovf", err_overflow, 1'b1);
        repeat (4) clear_ip();
        check("t3_drained", fifo_level, 3'd0);
        check("t3_sb_empty", sb_q.size(), 0);

        // 4: push and pop in the same cycle while full
        drive(4'b0010, 32'h4001, 16'd40, 4'b0010, "t4_fill1");
        drive(4'b0100, 32'h4002, 16'd40, 4'b0100, "t4_fill2");
        drive(4'b1000, 32'h4003, 16'd40, 4'b1000, "t4_fill3");
        drive(4'b0001, 32'h4000, 16'd40, 4'b0001, "t4_fill0");
        check("t4_full", fifo_level, 3'd4);
        sw_ip_clr = 1'b1; idle(1); sw_ip_clr = 1'b0;
        drive(4'b0100, 32'h4444, 16'd44, 4'b0100, "t4_ack");
        check("t4_de", last_de, 1'b1);
        check("t4_level", fifo_level, 3'd4);
        check("t4_cnt", err_drop_cnt, 8'd1);
        repeat (4) clear_ip();
        check("t4_sb_empty", sb_q.size(), 0);

        // 5: saturation under repeated collisions, then clear wins
        drive(4'b1000, 32'h5003, 16'd50, 4'b1000, "t5_fill3");
        drive(4'b0001, 32'h5000, 16'd50, 4'b0001, "t5_fill0");
        drive(4'b0010, 32'h5001, 16'd50, 4'b0010, "t5_fill1");
        drive(4'b0100, 32'h5002, 16'd50, 4'b0100, "t5_fill2");
        for (int n = 0; n < 300; n++) drive(4'b0011, 32'h5500, 16'd55, 4'b0000, "t5_coll");
        check("t5_sat", err_drop_cnt, 8'hff);
        err_cnt_clr = 1'b1;
        drive(4'b0011, 32'h5600, 16'd56, 4'b0000, "t5_clr_coll");
        err_cnt_clr = 1'b0;
        check("t5_cleared", err_drop_cnt, 8'd0);
        check("t5_ovf_clr", err_overflow, 1'b0);

        // 6: asynchronous reset with pending entries
        do_reset();
        set_ip();
        for (int i = 0; i < 3; i++) begin
            drive(4'(1 << i), 32'h6000 + 32'(i), 16'd60, 4'(1 << i), "t6_fill");
        end
        check("t6_level3", fifo_level, 3'd3);
        #2;
        err_if[1] = mk(1, 32'h6666, 16'd66);
        rst_ni = 1'b0;
        #1;
        check("t6_rst_level", fifo_level, 3'd0);
        check("t6_rst_ack", err_ack, 4'd0);
        check("t6_rst_de", hw2reg_err_reqinfo.ip.de, 1'b0);
        sb_q.delete();
        err_if = '0;
        idle(2);
        rst_ni = 1'b1;
        idle(1);
        drive(4'b1000, 32'h7000, 16'd70, 4'b1000, "t6_post_ack");
        @(negedge clk_i);
        check("t6_post_de", hw2reg_err_reqinfo.ip.de, 1'b1);
        @(posedge clk_i); #1;
        check("t6_post_ip", ip_q, 1'b1);
        check("t6_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
